exc_ctrl: RTL

Exception and interrupt controller, the consumer side of the CP0 register block. It takes the CP0 Status/Cause/EPC outputs, with a bypass for an in-flight mtc0, and the exception flags of the instruction in the MEM stage. It decides whether an exception, interrupt or eret is taken, then drives the pipeline flush and redirect PC. It also issues the CP0 exception-entry update (EPC, Cause.ExcCode/BD, Status.EXL) and the eret update (clear EXL).

---
 rtl/exc_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/exc_ctrl.sv
// ============================================================================
// Module   : exc_ctrl
// Brief    : Exception/interrupt/eret controller driving pipeline flush,
//            redirect PC and the CP0 exception-entry / eret updates.
// Revision : 1.0
// ============================================================================
`default_nettype none

module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
    parameter int          HOLD_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [4:0]  mem_exc_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        cp0_we_i,
    input  logic [4:0]  cp0_waddr_i,
    input  logic [31:0] cp0_wdata_i,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        exc_we_o,
    output logic [4:0]  exc_code_o,
    output logic [31:0] exc_epc_o,
    output logic        exc_bd_o,
    output logic        eret_o,
    output logic        busy_o
);

    localparam logic [3:0] C_HOLD = 4'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;

    logic [31:0] w_st;
    logic [31:0] w_ca;
    logic [31:0] w_ep;
    logic        w_int;
    logic        w_take;
    logic        w_is_eret;
    logic [4:0]  w_code;
    logic        w_unused;

    // mtc0 in WB is bypassed so a just-written Status/Cause/EPC is seen now
    assign w_st  = (cp0_we_i && cp0_waddr_i == 5'd12) ? cp0_wdata_i : status_i;
    assign w_ca  = (cp0_we_i && cp0_waddr_i == 5'd13)
                 ? {cause_i[31:10], cp0_wdata_i[9:8], cause_i[7:0]} : cause_i;
    assign w_ep  = (cp0_we_i && cp0_waddr_i == 5'd14) ? cp0_wdata_i : epc_i;
    assign w_int = w_st[0] & ~w_st[1] & (|(w_ca[15:8] & w_st[15:8]));

    assign w_unused = ^{w_st[31:16], w_st[7:2], w_ca[31:16], w_ca[7:0]};

    always_comb begin
        w_take    = 1'b0;
        w_is_eret = 1'b0;
        w_code    = 5'h00;
        if (r_state == S_IDLE && mem_valid_i) begin
            if (w_int) begin
                w_take = 1'b1;
                w_code = 5'h00;
            end else if (mem_exc_i[0]) begin
                w_take = 1'b1;
                w_code = 5'h08;
            end else if (mem_exc_i[1]) begin
                w_take = 1'b1;
                w_code = 5'h0a;
            end else if (mem_exc_i[2]) begin
                w_take = 1'b1;
                w_code = 5'h0d;
            end else if (mem_exc_i[3]) begin
                w_take = 1'b1;
                w_code = 5'h0c;
            end else if (mem_exc_i[4]) begin
                w_take    = 1'b1;
                w_is_eret = 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_take) w_next = S_FLUSH;
            S_FLUSH: w_next = S_HOLD;
            S_HOLD:  if (r_cnt <= 4'd1) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FLUSH) begin
                r_cnt <= C_HOLD;
            end else if (r_state == S_HOLD) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Payload outputs are loaded only on a taken request and otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_o    <= 1'b0;
            new_pc_o   <= 32'h0;
            exc_we_o   <= 1'b0;
            exc_code_o <= 5'h0;
            exc_epc_o  <= 32'h0;
            exc_bd_o   <= 1'b0;
            eret_o     <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            flush_o  <= w_take;
            exc_we_o <= w_take & ~w_is_eret;
            eret_o   <= w_take & w_is_eret;
            busy_o   <= (w_next != S_IDLE);
            if (w_take) begin
                new_pc_o <= w_is_eret ? w_ep : EXC_VECTOR;
                if (!w_is_eret) begin
                    exc_code_o <= w_code;
                    exc_epc_o  <= mem_in_delayslot_i ? (mem_pc_i - 32'd4) : mem_pc_i;
                    exc_bd_o   <= mem_in_delayslot_i;
                end
            end
        end
    end

endmodule

`default_nettype wire
